// File: rtl/trap_pkg.sv
//==============================================================================
// Module      : trap_pkg
// Description : Shared types and constants for the machine-mode trap sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package trap_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        T_EPC    = 3'd1,
        T_CAUSE  = 3'd2,
        T_STATUS = 3'd3,
        M_STATUS = 3'd4,
        REDIR    = 3'd5
    } trap_state_e;

    typedef enum logic {
        KIND_TRAP = 1'b0,
        KIND_RET  = 1'b1
    } trap_kind_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] CAUSE_ECALL_M   = 32'd11;
    localparam logic [31:0] CAUSE_IRQ_EXT_M = 32'h8000_000B;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Trap entry: stash MIE in MPIE, mask interrupts, record M-mode as previous.
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] mstatus_on_ret(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trap_prio.sv
//==============================================================================
// Module      : trap_prio
// Description : Qualifies trap/return requests and picks one by priority.
//               TRAP_CTRL_IRQ_EN enables the gated external interrupt path.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module trap_prio
    import trap_pkg::*;
(
    input  logic        inst_valid,
    input  logic        ecall,
    input  logic        mret,
    input  logic        irq,
    input  logic        mie,
    output logic        accept,
    output trap_kind_e  kind,
    output logic [31:0] cause
);

`ifndef TRAP_CTRL_IRQ_EN
    logic w_unused_irq;
    assign w_unused_irq = irq ^ mie;
`endif

    always_comb begin
        accept = 1'b0;
        kind   = KIND_TRAP;
        cause  = CAUSE_ECALL_M;
        if (inst_valid) begin
`ifdef TRAP_CTRL_IRQ_EN
            if (irq && mie) begin
                accept = 1'b1;
                cause  = CAUSE_IRQ_EXT_M;
            end else if (ecall) begin
                accept = 1'b1;
            end else if (mret) begin
                accept = 1'b1;
                kind   = KIND_RET;
            end
`else
            if (ecall) begin
                accept = 1'b1;
            end else if (mret) begin
                accept = 1'b1;
                kind   = KIND_RET;
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/trap_ctrl.sv
//==============================================================================
// Module      : trap_ctrl
// Description : Machine-mode trap entry/return sequencer and CSR write-port
//               arbiter. TRAP_CTRL_IRQ_EN enables the external interrupt path.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module trap_ctrl
    import trap_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    input  logic [31:0] inst_pc,
    input  logic        ecall,
    input  logic        mret,
    input  logic        irq,
    input  logic [31:0] mstatus,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        pipe_csr_we,
    input  logic [11:0] pipe_csr_idx,
    input  logic [31:0] pipe_csr_wdata,
    output logic        csr_we,
    output logic [11:0] csr_idx,
    output logic [31:0] csr_wdata,
    output logic        stall,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    trap_state_e r_state;
    trap_state_e w_next;
    trap_kind_e  r_kind;
    trap_kind_e  w_kind;
    logic [31:0] r_pc;
    logic [31:0] r_cause;
    logic [31:0] w_cause;
    logic        w_accept;
    logic        w_unused_mtvec;

    assign w_unused_mtvec = ^mtvec[1:0];

    trap_prio u_prio (
        .inst_valid (inst_valid),
        .ecall      (ecall),
        .mret       (mret),
        .irq        (irq),
        .mie        (mstatus[MSTATUS_MIE]),
        .accept     (w_accept),
        .kind       (w_kind),
        .cause      (w_cause)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_kind  <= KIND_TRAP;
            r_pc    <= '0;
            r_cause <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_accept) begin
                r_kind  <= w_kind;
                r_pc    <= inst_pc;
                r_cause <= w_cause;
            end
        end
    end

    assign busy  = (r_state != IDLE);
    assign stall = ((r_state == IDLE) && w_accept) || busy;

    always_comb begin
        w_next         = r_state;
        csr_we         = 1'b0;
        csr_idx        = '0;
        csr_wdata      = '0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (r_state)
            IDLE: begin
                // An accepted request owns the port; the pipe write belongs to a killed instruction.
                if (w_accept) begin
                    w_next = (w_kind == KIND_RET) ? M_STATUS : T_EPC;
                end else begin
                    csr_we    = pipe_csr_we;
                    csr_idx   = pipe_csr_idx;
                    csr_wdata = pipe_csr_wdata;
                end
            end
            T_EPC: begin
                csr_we    = 1'b1;
                csr_idx   = CSR_MEPC;
                csr_wdata = r_pc;
                w_next    = T_CAUSE;
            end
            T_CAUSE: begin
                csr_we    = 1'b1;
                csr_idx   = CSR_MCAUSE;
                csr_wdata = r_cause;
                w_next    = T_STATUS;
            end
            T_STATUS: begin
                csr_we    = 1'b1;
                csr_idx   = CSR_MSTATUS;
                csr_wdata = mstatus_on_trap(mstatus);
                w_next    = REDIR;
            end
            M_STATUS: begin
                csr_we    = 1'b1;
                csr_idx   = CSR_MSTATUS;
                csr_wdata = mstatus_on_ret(mstatus);
                w_next    = REDIR;
            end
            REDIR: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = (r_kind == KIND_RET) ? mepc : {mtvec[31:2], 2'b00};
                w_next         = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
//==============================================================================
// Module      : tb_trap_ctrl
// Description : Directed self-checking bench for trap_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_trap_ctrl;

    logic        clk;
    logic        rst_n;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic        ecall;
    logic        mret;
    logic        irq;
    logic [31:0] mstatus;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        pipe_csr_we;
    logic [11:0] pipe_csr_idx;
    logic [31:0] pipe_csr_wdata;
    logic        csr_we;
    logic [11:0] csr_idx;
    logic [31:0] csr_wdata;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    logic [80:0] obs;
    int          n_vec;
    int          n_err;

`ifdef TRAP_CTRL_IRQ_EN
    localparam logic [31:0] C_IRQ_CAUSE = 32'h8000_000B;
`else
    localparam logic [31:0] C_IRQ_CAUSE = 32'd11;
`endif

    trap_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inst_valid     (inst_valid),
        .inst_pc        (inst_pc),
        .ecall          (ecall),
        .mret           (mret),
        .irq            (irq),
        .mstatus        (mstatus),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .pipe_csr_we    (pipe_csr_we),
        .pipe_csr_idx   (pipe_csr_idx),
        .pipe_csr_wdata (pipe_csr_wdata),
        .csr_we         (csr_we),
        .csr_idx        (csr_idx),
        .csr_wdata      (csr_wdata),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    assign obs = {csr_we, csr_idx, csr_wdata, stall, flush, redirect_valid, redirect_pc, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [80:0] ev(input logic we, input logic [11:0] idx, input logic [31:0] d,
                                       input logic st, input logic fl, input logic rv,
                                       input logic [31:0] rpc, input logic bz);
        return {we, idx, d, st, fl, rv, rpc, bz};
    endfunction

    task automatic test_reset();
        #3;
        n_vec++;
        if (obs !== ev(0, 0, 0, 0, 0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL reset_held: got %h want %h", obs, ev(0, 0, 0, 0, 0, 0, 0, 0));
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        n_vec++;
        if (obs !== ev(0, 0, 0, 0, 0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL reset_release: got %h want %h", obs, ev(0, 0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_ecall();
        logic [80:0] exp [0:5];
        mstatus = 32'h8; mtvec = 32'h205; mepc = 32'h0;
        exp[0] = ev(0, 12'h000, 32'h0,    1, 0, 0, 32'h0,   0);
        exp[1] = ev(1, 12'h341, 32'h100,  1, 0, 0, 32'h0,   1);
        exp[2] = ev(1, 12'h342, 32'd11,   1, 0, 0, 32'h0,   1);
        exp[3] = ev(1, 12'h300, 32'h1880, 1, 0, 0, 32'h0,   1);
        exp[4] = ev(0, 12'h000, 32'h0,    1, 1, 1, 32'h204, 1);
        exp[5] = ev(0, 12'h000, 32'h0,    0, 0, 0, 32'h0,   0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            inst_pc = 32'h100; inst_valid = (c < 4); ecall = (c < 4);
            #2;
            n_vec++;
            if (obs !== exp[c]) begin
                n_err++;
                $display("FAIL ecall_c%0d: got %h want %h", c, obs, exp[c]);
            end
        end
    endtask

    task automatic test_mret();
        logic [80:0] exp [0:3];
        mstatus = 32'h1880; mtvec = 32'h205; mepc = 32'h104;
        exp[0] = ev(0, 12'h000, 32'h0,    1, 0, 0, 32'h0,   0);
        exp[1] = ev(1, 12'h300, 32'h1888, 1, 0, 0, 32'h0,   1);
        exp[2] = ev(0, 12'h000, 32'h0,    1, 1, 1, 32'h104, 1);
        exp[3] = ev(0, 12'h000, 32'h0,    0, 0, 0, 32'h0,   0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            inst_pc = 32'h200; inst_valid = (c < 2); mret = (c < 2);
            #2;
            n_vec++;
            if (obs !== exp[c]) begin
                n_err++;
                $display("FAIL mret_c%0d: got %h want %h", c, obs, exp[c]);
            end
        end
    endtask

    // irq coincident with ecall, first with MIE=1 then MIE=0
    task automatic test_irq();
        logic [80:0] exp [0:5];
        for (int p = 0; p < 2; p++) begin
            mstatus = (p == 0) ? 32'h8 : 32'h0; mtvec = 32'h205;
            exp[0] = ev(0, 12'h000, 32'h0,  1, 0, 0, 32'h0,   0);
            exp[1] = ev(1, 12'h341, 32'h40, 1, 0, 0, 32'h0,   1);
            exp[2] = ev(1, 12'h342, (p == 0) ? C_IRQ_CAUSE : 32'd11, 1, 0, 0, 32'h0, 1);
            exp[3] = ev(1, 12'h300, (p == 0) ? 32'h1880 : 32'h1800, 1, 0, 0, 32'h0, 1);
            exp[4] = ev(0, 12'h000, 32'h0,  1, 1, 1, 32'h204, 1);
            exp[5] = ev(0, 12'h000, 32'h0,  0, 0, 0, 32'h0,   0);
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                inst_pc = 32'h40; inst_valid = (c < 4); ecall = (c < 4); irq = (c < 4);
                #2;
                n_vec++;
                if (obs !== exp[c]) begin
                    n_err++;
                    $display("FAIL irq_p%0d_c%0d: got %h want %h", p, c, obs, exp[c]);
                end
            end
        end
    endtask

    // A lone irq must not be taken: masked by MIE=0, or compiled out entirely.
    task automatic test_irq_only();
`ifdef TRAP_CTRL_IRQ_EN
        mstatus = 32'h0;
`else
        mstatus = 32'h8;
`endif
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            inst_pc = 32'h60; inst_valid = 1'b1; irq = 1'b1;
            #2;
            n_vec++;
            if (obs !== ev(0, 0, 0, 0, 0, 0, 0, 0)) begin
                n_err++;
                $display("FAIL irq_only_c%0d: got %h want %h", c, obs, ev(0, 0, 0, 0, 0, 0, 0, 0));
            end
        end
        @(negedge clk);
        inst_valid = 1'b0; irq = 1'b0;
    endtask

    task automatic test_pipe_arb();
        logic [80:0] exp [0:6];
        mstatus = 32'h8; mtvec = 32'h205;
        exp[0] = ev(1, 12'h340, 32'hAB,   0, 0, 0, 32'h0,   0);
        exp[1] = ev(0, 12'h000, 32'h0,    1, 0, 0, 32'h0,   0);
        exp[2] = ev(1, 12'h341, 32'h80,   1, 0, 0, 32'h0,   1);
        exp[3] = ev(1, 12'h342, 32'd11,   1, 0, 0, 32'h0,   1);
        exp[4] = ev(1, 12'h300, 32'h1880, 1, 0, 0, 32'h0,   1);
        exp[5] = ev(0, 12'h000, 32'h0,    1, 1, 1, 32'h204, 1);
        exp[6] = ev(1, 12'h340, 32'hAB,   0, 0, 0, 32'h0,   0);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            pipe_csr_we = 1'b1; pipe_csr_idx = 12'h340; pipe_csr_wdata = 32'hAB;
            inst_pc = 32'h80; inst_valid = (c >= 1 && c < 5); ecall = (c >= 1 && c < 5);
            #2;
            n_vec++;
            if (obs !== exp[c]) begin
                n_err++;
                $display("FAIL pipe_arb_c%0d: got %h want %h", c, obs, exp[c]);
            end
        end
        @(negedge clk);
        pipe_csr_we = 1'b0; pipe_csr_idx = '0; pipe_csr_wdata = '0;
    endtask

    task automatic test_reset_abort();
        logic [80:0] exp [0:2];
        mstatus = 32'h8; mtvec = 32'h205;
        exp[0] = ev(0, 12'h000, 32'h0,  1, 0, 0, 32'h0, 0);
        exp[1] = ev(1, 12'h341, 32'h90, 1, 0, 0, 32'h0, 1);
        exp[2] = ev(1, 12'h342, 32'd11, 1, 0, 0, 32'h0, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            inst_pc = 32'h90; inst_valid = 1'b1; ecall = 1'b1;
            #2;
            n_vec++;
            if (obs !== exp[c]) begin
                n_err++;
                $display("FAIL abort_c%0d: got %h want %h", c, obs, exp[c]);
            end
        end
        #1;
        rst_n = 1'b0; inst_valid = 1'b0; ecall = 1'b0;
        #1;
        n_vec++;
        if (obs !== ev(0, 0, 0, 0, 0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL abort_immediate: got %h want %h", obs, ev(0, 0, 0, 0, 0, 0, 0, 0));
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (obs !== ev(0, 0, 0, 0, 0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL abort_held: got %h want %h", obs, ev(0, 0, 0, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; inst_valid = 1'b0; inst_pc = '0; ecall = 1'b0; mret = 1'b0; irq = 1'b0;
        mstatus = '0; mtvec = '0; mepc = '0;
        pipe_csr_we = 1'b0; pipe_csr_idx = '0; pipe_csr_wdata = '0;
        test_reset();
        test_ecall();
        test_mret();
        test_irq();
        test_irq_only();
        test_pipe_arb();
        test_reset_abort();
        test_ecall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/trap_ctrl.md
# trap_ctrl

Sequencer for machine-mode trap entry and return, sitting between the instruction decoder and the CSR file. It detects ECALL, MRET and a gated external interrupt, and stalls the pipeline while it works. It also owns the CSR file's single write port: pipeline CSRRW/CSRRS/CSRRC writes and its own multi-cycle mepc/mcause/mstatus update sequence share that port. It finishes by issuing a PC redirect plus flush to mtvec or mepc.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inst_valid  in  1  instruction at CSR stage is valid.
- inst_pc  in  32  PC of that instruction.
- ecall  in  1  decoded ECALL, qualified by inst_valid.
- mret  in  1  decoded MRET, qualified by inst_valid.
- irq  in  1  level-sensitive external interrupt.
- mstatus, mtvec, mepc  in  32 each  current CSR values, read-only view.
- pipe_csr_we  in  1  pipeline CSR write request.
- pipe_csr_idx  in  12  pipeline CSR write index.
- pipe_csr_wdata  in  32  pipeline CSR write data.
- csr_we  out  1  CSR write-port enable.
- csr_idx  out  12  CSR write-port index.
- csr_wdata  out  32  CSR write-port data.
- stall  out  1  holds all pipeline stages.
- flush  out  1  kills the instruction at the CSR stage and younger instructions.
- redirect_valid  out  1  one-cycle PC override.
- redirect_pc  out  32  override target.
- busy  out  1  FSM is not IDLE.

## Operation
- States: IDLE, T_EPC, T_CAUSE, T_STATUS, M_STATUS, REDIR.
- Request in IDLE (only when inst_valid=1), by priority:
  - irq: only if mstatus[3]=1 (MIE).
  - ecall.
  - mret.
- Transitions:
  - irq or ecall: IDLE→T_EPC→T_CAUSE→T_STATUS→REDIR→IDLE.
  - mret: IDLE→M_STATUS→REDIR→IDLE.
- Latched on acceptance: inst_pc, cause, target select (trap or return).
- T_EPC: csr_we=1, idx 0x341, data = latched pc.
- T_CAUSE: idx 0x342, data 32'd11 for ecall, 32'h8000_000B for irq.
- T_STATUS: idx 0x300, data = mstatus with:
  - bit7 (MPIE) ← bit3 (MIE).
  - bit3 ← 0.
  - bits[12:11] ← 2'b11.
- M_STATUS: idx 0x300, data = mstatus with bit3 ← bit7 and bit7 ← 1.
- REDIR: redirect_valid=1, flush=1.
  - Trap: redirect_pc = {mtvec[31:2],2'b00}.
  - Return: redirect_pc = mepc.
- IDLE with no accepted request: port passes pipe_csr_* through unchanged.
- IDLE with a request accepted in the same cycle as pipe_csr_we: the pipe write is dropped, because that instruction is trapped or flushed.
- Non-IDLE states: pipe_csr_we is ignored; the pipeline is stalled, so it re-presents the write later.
- Requests arriving while busy are ignored. irq is re-evaluated in IDLE after REDIR; by then MIE=0 after trap entry, so it is not taken again.

## Timing
- Reset: state IDLE; latches cleared.
- Output values at reset: csr_we=0, csr_idx=0, csr_wdata=0, stall=0, flush=0, redirect_valid=0, redirect_pc=0, busy=0.
- stall is combinational: (IDLE & accepted request) | busy. It is high from the request cycle through REDIR inclusive.
- CSR write outputs are Moore, decoded from state and latches, except the IDLE pass-through.
- Trap latency: request at cycle 0; writes at cycles 1, 2, 3; redirect at cycle 4. Mret: write at cycle 1, redirect at cycle 2.
- mstatus and mepc are sampled in the cycle they are used. The CSR file updates on the edge after csr_we, so M_STATUS and REDIR see committed values.
- Reset assertion mid-sequence aborts to IDLE immediately. Any CSR writes already done remain; no redirect is issued.

## Configuration
- TRAP_CTRL_IRQ_EN defined: irq path compiled in as described.
- TRAP_CTRL_IRQ_EN undefined:
  - irq is ignored.
  - cause is always 32'd11.
  - Priority is ecall > mret.

## Structure
- trap_pkg holds:
  - The state enum.
  - CSR index constants MSTATUS=0x300, MTVEC=0x305, MEPC=0x341, MCAUSE=0x342.
  - Cause constants.
  - mstatus bit positions: MIE=3, MPIE=7, MPP=12:11.
- One sub-module, trap_prio: combinational request qualification and priority encoding. It outputs accept, kind and cause.

## Test plan
- ECALL at pc 0x100, mtvec 0x205, mstatus 0x8: stall for 5 cycles. Writes in order:
  - 0x341←0x100.
  - 0x342←11.
  - 0x300←0x1880.
  - Then redirect_pc 0x204 with flush.
- MRET with mepc 0x104, mstatus 0x1880: write 0x300←0x1888, then redirect to 0x104 at cycle 2.
- irq=1 with MIE=1 coincident with ecall at pc 0x40: cause 0x8000000B, epc 0x40. With MIE=0: ecall path taken, cause 11.
- pipe_csr_we idx 0x340 data 0xAB in IDLE, no request: same-cycle pass-through. Issued during T_CAUSE: no write from the pipe in that cycle.
- rst_n dropped during T_CAUSE: all outputs 0 immediately; after release, the next ECALL runs the full sequence.
- TRAP_CTRL_IRQ_EN undefined, irq=1 with MIE=1 and no ecall: no stall, no writes.
